host_run_bridge: RTL and testbench

- Host-side command bridge giving an external host (tester, debug port) the same control a bench has over the core.
- The host loads data memory, releases the core from reset, waits for done, then reads results back.
- Sits between the host command channel and the core: drives the core reset and owns the data-memory port while the core is held.
- Acts as the responder to the host-initiated load/run/readback sequence.

---
 rtl/host_run_bridge.sv | 166 ++++++++++++++++
 tb/tb_host_run_bridge.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_run_bridge.sv
// Host command bridge: lets an external host load data memory, run the core, and read results back.
// Define HOST_TIMEOUT_EN to enable the RUN watchdog (TIMEOUT cycles in WAIT without core_done).
module host_run_bridge #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned HOLD_CYC = 2,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [15:0]   run_cycles,
  output logic          mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_reset,
  input  logic          core_done
);

  localparam int unsigned HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYC - 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;

`ifdef HOST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_ADDR, S_RD_CAP, S_HOLD, S_WAIT, S_FIN, S_RSP
  } state_t;

  state_t         state, state_nx;
  logic [HCW-1:0] hold_cnt, hold_cnt_nx;
  logic [15:0]    run_cycles_nx;
  logic [DW-1:0]  rsp_data_nx;
  logic           rsp_err_nx;
  logic [AW-1:0]  mem_addr_nx;
  logic [DW-1:0]  mem_wdata_nx;
  logic           cmd_ready_nx;
  logic           rsp_valid_nx;
  logic           mem_we_nx;
  logic           mem_sel_nx;
  logic           core_reset_nx;

  // State and all outputs are registered; next values come from the block below.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      run_cycles <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_sel    <= 1'b1;
      core_reset <= 1'b1;
    end else begin
      state      <= state_nx;
      hold_cnt   <= hold_cnt_nx;
      run_cycles <= run_cycles_nx;
      rsp_data   <= rsp_data_nx;
      rsp_err    <= rsp_err_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      cmd_ready  <= cmd_ready_nx;
      rsp_valid  <= rsp_valid_nx;
      mem_we     <= mem_we_nx;
      mem_sel    <= mem_sel_nx;
      core_reset <= core_reset_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx      = state;
    hold_cnt_nx   = hold_cnt;
    run_cycles_nx = run_cycles;
    rsp_data_nx   = rsp_data;
    rsp_err_nx    = rsp_err;
    mem_addr_nx   = mem_addr;
    mem_wdata_nx  = mem_wdata;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          mem_addr_nx  = cmd_addr;
          mem_wdata_nx = cmd_wdata;
          case (cmd_op)
            OP_WRITE: state_nx = S_WR;
            OP_READ:  state_nx = S_RD_ADDR;
            OP_RUN: begin
              state_nx    = S_HOLD;
              hold_cnt_nx = '0;
            end
            default: begin
              state_nx    = S_RSP;
              rsp_data_nx = '0;
              rsp_err_nx  = 1'b1;
            end
          endcase
        end
      end
      S_WR: begin
        state_nx    = S_RSP;
        rsp_data_nx = '0;
        rsp_err_nx  = 1'b0;
      end
      S_RD_ADDR: state_nx = S_RD_CAP;
      S_RD_CAP: begin
        state_nx    = S_RSP;
        rsp_data_nx = mem_rdata;
        rsp_err_nx  = 1'b0;
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nx      = S_WAIT;
          run_cycles_nx = '0;
        end else begin
          hold_cnt_nx = hold_cnt + HCW'(1);
        end
      end
      S_WAIT: begin
        // Count includes the cycle in which done is sampled.
        run_cycles_nx = (run_cycles == 16'hFFFF) ? run_cycles : run_cycles + 16'd1;
        if (core_done) begin
          state_nx    = S_FIN;
          rsp_data_nx = DW'(run_cycles_nx);
          rsp_err_nx  = 1'b0;
        end else if (TO_EN && (run_cycles_nx == TIMEOUT)) begin
          state_nx    = S_FIN;
          rsp_data_nx = '1;
          rsp_err_nx  = 1'b1;
        end
      end
      S_FIN: state_nx = S_RSP;
      S_RSP: begin
        if (rsp_valid && rsp_ready) state_nx = S_IDLE;
      end
    endcase

    cmd_ready_nx  = (state_nx == S_IDLE);
    rsp_valid_nx  = (state_nx == S_RSP);
    mem_we_nx     = (state_nx == S_WR);
    mem_sel_nx    = !((state_nx == S_HOLD) || (state_nx == S_WAIT));
    core_reset_nx = (state_nx != S_WAIT);
  end

endmodule

// File: tb/tb_host_run_bridge.sv
// Randomized scoreboard bench for host_run_bridge: memory model, host driver, response monitor.
// Build with +define+HOST_TIMEOUT_EN to exercise the RUN watchdog path.
module tb_host_run_bridge;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned HOLD_CYC = 2;
  localparam logic [15:0] TIMEOUT = 16'd100;
`ifdef HOST_TIMEOUT_EN
  localparam int N_HANG = 20;
`else
  localparam int N_HANG = 300;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [15:0]   run_cycles;
  logic          mem_sel, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          core_reset, core_done;

  always #5 clk = ~clk;

  host_run_bridge #(.AW(AW), .DW(DW), .HOLD_CYC(HOLD_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .run_cycles(run_cycles),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .core_reset(core_reset), .core_done(core_done)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    bit            chk_rc;
    logic [15:0]   rc;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            we_count = 0;
  bit            force_low = 1'b0;
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] ref_mem [2**AW];
  logic [AW-1:0] waddrs[$];

  // Data memory with 1-cycle read latency; host side writes only when the bridge owns it.
  always @(posedge clk) begin
    if (mem_sel && mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // Response ready: random, or held low for backpressure.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: ownership rule, response stability, scoreboard compare on handshake.
  initial begin
    bit            prev_hold;
    logic [DW:0]   prev_rsp;
    exp_t          e;
    prev_hold = 1'b0;
    prev_rsp  = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (mem_we) begin
          we_count++;
          chk("we_owner", 32'(mem_sel), 32'd1);
        end
        if (rsp_valid && prev_hold) chk("rsp_stable", 32'({rsp_err, rsp_data}), 32'(prev_rsp));
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            fail("unexpected_rsp");
          end else begin
            e = sb.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(e.data));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            if (e.chk_rc) chk("run_cycles", 32'(run_cycles), 32'(e.rc));
          end
        end
        prev_hold = rsp_valid && !rsp_ready;
        prev_rsp  = {rsp_err, rsp_data};
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output bit ok);
    int n;
    @(negedge clk);
    cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      fail("cmd_accept_timeout");
      cmd_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    cmd_op    = 2'($urandom);
    ok = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !cmd_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) fail("idle_timeout");
  endtask

  // WRITE / READ / reserved: scoreboard entry, latency to rsp_valid, write-strobe count.
  task automatic do_op(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    bit   ok;
    int   lat, exp_lat, w0;
    e.chk_rc = 1'b0;
    e.rc = '0;
    case (op)
      2'b00:   begin e.data = '0;         e.err = 1'b0; exp_lat = 2; end
      2'b01:   begin e.data = ref_mem[a]; e.err = 1'b0; exp_lat = 3; end
      default: begin e.data = '0;         e.err = 1'b1; exp_lat = 1; end
    endcase
    sb.push_back(e);
    w0 = we_count;
    send(op, a, d, ok);
    if (!ok) return;
    if (op == 2'b00) begin
      ref_mem[a] = d;
      waddrs.push_back(a);
    end
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    wait_idle();
    chk("we_pulses", 32'(we_count - w0), (op == 2'b00) ? 32'd1 : 32'd0);
  endtask

  // RUN with core_done raised d cycles after the first WAIT cycle (d=0: already high during HOLD).
  task automatic do_run(input int d);
    exp_t e;
    bit   ok;
    int   n, hold, sel_bad;
    e.data = DW'(d + 1);
    e.err = 1'b0;
    e.chk_rc = 1'b1;
    e.rc = 16'(d + 1);
    sb.push_back(e);
    if (d == 0) core_done = 1'b1;
    send(2'b10, AW'($urandom), DW'($urandom), ok);
    if (!ok) return;
    n = 0;
    hold = 0;
    @(negedge clk);
    while (core_reset && n < 50) begin
      if (!mem_sel) hold++;
      n++;
      @(negedge clk);
    end
    chk("hold_cycles", 32'(hold), 32'(HOLD_CYC));
    sel_bad = 0;
    repeat (d) begin
      if (mem_sel || core_reset) sel_bad++;
      @(negedge clk);
    end
    core_done = 1'b1;
    n = 0;
    while (!core_reset && n < 50) begin
      if (mem_sel) sel_bad++;
      @(negedge clk);
      n++;
    end
    chk("wait_ownership", 32'(sel_bad), 32'd0);
    chk("run_end_release", 32'({core_reset, mem_sel}), 32'b11);
    core_done = 1'b0;
    wait_idle();
  endtask

  task automatic start_hang(output bit ok);
    int n;
    core_done = 1'b0;
    send(2'b10, AW'($urandom), DW'($urandom), ok);
    if (!ok) return;
    n = 0;
    while (core_reset && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (core_reset) begin
      fail("wait_entry_timeout");
      ok = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    bit            ok;
    int            seen, n, r;
    logic [DW-1:0] d0;
    logic          e0;
    exp_t          e;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    core_done = 1'b0;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'({cmd_ready, rsp_valid, rsp_err, mem_sel, mem_we, core_reset}), 32'b000101);
    chk("reset_data", 32'({rsp_data, mem_addr, mem_wdata}), 32'd0);
    chk("reset_run_cycles", 32'(run_cycles), 32'd0);
    reset_n = 1'b1;

    // Directed: write then read back, reserved op, long run.
    do_op(2'b00, 8'd1, 8'h0C);
    do_op(2'b01, 8'd1, 8'h00);
    do_op(2'b11, 8'd5, 8'hA5);
    do_run(37);
    do_run(0);

    // Backpressure on a READ response.
    force_low = 1'b1;
    repeat (3) @(negedge clk);
    e.data = 8'h0C; e.err = 1'b0; e.chk_rc = 1'b0; e.rc = '0;
    sb.push_back(e);
    n = we_count;
    send(2'b01, 8'd1, 8'h00, ok);
    r = 0;
    while (!rsp_valid && r < 20) begin
      @(negedge clk);
      r++;
    end
    d0 = rsp_data;
    e0 = rsp_err;
    chk("bp_data", 32'({e0, d0}), 32'h00C);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== d0 || rsp_err !== e0 || cmd_ready || mem_we) seen++;
    end
    chk("bp_hold", 32'(seen), 32'd0);
    chk("bp_no_we", 32'(we_count - n), 32'd0);
    force_low = 1'b0;
    wait_idle();

    // Randomized mix checked against the reference memory and run-count rule.
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4 || (r < 7 && waddrs.size() == 0))
        do_op(2'b00, AW'($urandom_range(0, 31)), DW'($urandom));
      else if (r < 7)
        do_op(2'b01, waddrs[$urandom_range(0, waddrs.size() - 1)], DW'($urandom));
      else if (r == 7)
        do_op(2'b11, AW'($urandom), DW'($urandom));
      else
        do_run($urandom_range(0, 20));
    end

`ifdef HOST_TIMEOUT_EN
    e.data = 8'hFF; e.err = 1'b1; e.chk_rc = 1'b1; e.rc = TIMEOUT;
    sb.push_back(e);
    start_hang(ok);
    n = 0;
    while (!core_reset && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_release", 32'({core_reset, mem_sel}), 32'b11);
    wait_idle();
`endif

    // Run that never completes, then reset mid-WAIT.
    start_hang(ok);
    seen = 0;
    repeat (N_HANG) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("hang_no_rsp", 32'({seen[15:0], core_reset}), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_reset", 32'({core_reset, mem_sel, rsp_valid}), 32'b110);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_after_abort", 32'(cmd_ready), 32'd1);
    do_op(2'b00, 8'd9, 8'h5A);
    do_op(2'b01, 8'd9, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
